line_scheduler: RTL

LINE_SCHEDULER -- requirements
Module: line_scheduler

---
 rtl/line_scheduler_if.sv | 36 +++
 rtl/line_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/line_scheduler_if.sv
// Host/solver-facing bundle for the line scheduler: load path, solver
// read/write-back path and status outputs.
interface line_scheduler_if #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11,
    parameter int DEPTH    = 256
);
    localparam int NL_W  = $clog2(MAX_ROWS + MAX_COLS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              load_valid;
    logic [15:0]       load_data;
    logic              start;
    logic [NL_W-1:0]   num_lines;
    logic              rd_req;
    logic [15:0]       rd_data;
    logic              rd_valid;
    logic              wb_valid;
    logic [15:0]       wb_data;
    logic              solved;
    logic [CNT_W-1:0]  count;
    logic [7:0]        pass_cnt;
    logic              stalled;
    logic              overflow;
    logic              done;

    modport master (
        output load_valid, load_data, start, num_lines, rd_req, wb_valid, wb_data, solved,
        input  rd_data, rd_valid, count, pass_cnt, stalled, overflow, done
    );

    modport slave (
        input  load_valid, load_data, start, num_lines, rd_req, wb_valid, wb_data, solved,
        output rd_data, rd_valid, count, pass_cnt, stalled, overflow, done
    );
endinterface

// File: rtl/line_scheduler.sv
// Circular word store feeding a nonogram line solver. Headers (line index)
// and option bitmaps are loaded by the host, popped by the solver and
// optionally written back. Passes over the line set are tracked so that a
// pass with no dropped option is reported as a stall.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, store empty, waiting for the first host word
//   LOAD   | host filling the store, waiting for start
//   RUN    | serving solver pops and write-backs, tracking passes
//   DONE   | solved or stalled; only reset leaves this state
module line_scheduler #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11,
    parameter int DEPTH    = 256
) (
    input  logic             clk,
    input  logic             rst,
    line_scheduler_if.slave  bus
);
    localparam int NL_W  = $clog2(MAX_ROWS + MAX_COLS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [15:0]       r_rd_data;
    logic              r_rd_valid;
    logic [7:0]        r_pass_cnt;
    logic              r_stalled, r_overflow;
    logic [NL_W-1:0]   r_num_lines, r_hdr_cnt, w_exp_idx;
    logic              r_first;
    logic [15:0]       r_p, r_w, w_p_end, w_w_end;

    logic              w_loading, w_running;
    logic              w_push_req, w_push, w_push_run, w_pop, w_drop;
    logic [15:0]       w_push_data, w_pop_word;
    logic              w_is_hdr, w_hdr_end, w_zero_end, w_pass_end, w_stall, w_set_stall;

    assign w_loading   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_running   = (r_state == S_RUN) && !bus.solved;
    assign w_push_req  = (w_loading && bus.load_valid) || (w_running && bus.wb_valid);
    assign w_push_data = w_loading ? bus.load_data : bus.wb_data;
    assign w_pop       = w_running && bus.rd_req && (r_count != '0);
    // A full store still accepts a push when a pop frees a slot in the same cycle.
    assign w_push      = w_push_req && ((r_count != FULL) || w_pop);
    assign w_drop      = w_push_req && !w_push;
    assign w_push_run  = w_push && w_running;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_pop_word  = r_mem[r_rd_ptr];

    // Headers arrive in index order; after num_lines of them the next one is index 0 again.
    assign w_exp_idx  = (r_hdr_cnt == r_num_lines) ? '0 : r_hdr_cnt;
    assign w_is_hdr   = w_pop && (r_first || (w_pop_word == {{(16-NL_W){1'b0}}, w_exp_idx}));
    assign w_hdr_end  = w_is_hdr && !r_first && (r_hdr_cnt == r_num_lines);
    assign w_zero_end = w_pop && (w_count_nxt == '0) && !w_hdr_end;
    assign w_pass_end = w_hdr_end || w_zero_end;
    // The header that ends a pass belongs to the next pass; a draining pop belongs to this one.
    assign w_p_end    = r_p + 16'(w_zero_end);
    assign w_w_end    = r_w + 16'(w_push_run);
    assign w_stall    = w_pass_end && (w_p_end == w_w_end);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and stall-flag decision.
    always_comb begin
        w_state_nxt = r_state;
        w_set_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_valid) begin
                    w_state_nxt = S_LOAD;
                end else if (bus.start && (r_count == '0)) begin
                    w_state_nxt = S_DONE;
                    w_set_stall = 1'b1;
                end
            end
            S_LOAD: if (bus.start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.solved) begin
                    w_state_nxt = S_DONE;
                end else if (w_stall) begin
                    w_state_nxt = S_DONE;
                    w_set_stall = 1'b1;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    // Pointers, occupancy, read port and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_stalled   <= 1'b0;
            r_overflow  <= 1'b0;
            r_num_lines <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_pop)  r_rd_data <= w_pop_word;
            r_count    <= w_count_nxt;
            r_rd_valid <= w_pop;
            if (w_drop)      r_overflow <= 1'b1;
            if (w_set_stall) r_stalled  <= 1'b1;
            if ((r_state == S_LOAD) && bus.start) r_num_lines <= bus.num_lines;
        end
    end

    // Per-pass header, pop and write-back accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first    <= 1'b1;
            r_hdr_cnt  <= '0;
            r_p        <= '0;
            r_w        <= '0;
            r_pass_cnt <= '0;
        end else if (w_pass_end) begin
            if (r_pass_cnt != 8'hFF) r_pass_cnt <= r_pass_cnt + 8'd1;
            r_w <= '0;
            if (w_hdr_end) begin
                r_p       <= 16'd1;
                r_hdr_cnt <= NL_W'(1);
                r_first   <= 1'b0;
            end else begin
                r_p       <= '0;
                r_hdr_cnt <= '0;
                r_first   <= 1'b1;
            end
        end else begin
            if (w_pop)      r_p <= r_p + 16'd1;
            if (w_pop)      r_first <= 1'b0;
            if (w_push_run) r_w <= r_w + 16'd1;
            if (w_is_hdr)   r_hdr_cnt <= r_hdr_cnt + NL_W'(1);
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.count    = r_count;
    assign bus.pass_cnt = r_pass_cnt;
    assign bus.stalled  = r_stalled;
    assign bus.overflow = r_overflow;
    assign bus.done     = (r_state == S_DONE);
endmodule
